// File: rtl/accel_seq_pkg.sv
// accel_seq_pkg: shared types and defaults for the accelerator sweep driver.
//   - seq_state_e : sweep FSM states
//   - *_DEF       : default widths and watchdog limit
//   - res_rec_t   : {a, b, y} result record at the default data width, for
//                   host-side code that consumes the result port.
package accel_seq_pkg;

  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned CNT_W_DEF   = 9;
  localparam int unsigned TIMEOUT_DEF = 1023;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    GUARD  = 3'd2,
    WAIT   = 3'd3,
    REPORT = 3'd4
  } seq_state_e;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] a;
    logic [DATA_W_DEF-1:0] b;
    logic [DATA_W_DEF-1:0] y;
  } res_rec_t;

endpackage

// File: rtl/accel_seq_timeout.sv
// accel_seq_timeout: loadable down-counter used as the WAIT watchdog.
//   clk_i     : clock
//   rst_i     : asynchronous active-high reset (counter cleared)
//   load_i    : preload to LOAD_VAL-1
//   dec_i     : count one elapsed cycle (saturates at zero)
//   expired_o : counter is at zero, i.e. LOAD_VAL cycles have been counted
//               since the load (one per dec_i, including the current one)
module accel_seq_timeout #(
  parameter int unsigned LOAD_VAL = 1023,
  parameter int unsigned W        = $clog2(LOAD_VAL + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic dec_i,
  output logic expired_o
);

  localparam logic [W-1:0] LOAD_M1 = W'(LOAD_VAL - 1);
  localparam logic [W-1:0] ZERO_C  = {W{1'b0}};
  localparam logic [W-1:0] ONE_C   = W'(1);

  logic [W-1:0] cnt_r;

  // Watchdog count register: load has priority, decrement stops at zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_r <= ZERO_C;
    end else if (load_i) begin
      cnt_r <= LOAD_M1;
    end else if (dec_i && (cnt_r != ZERO_C)) begin
      cnt_r <= cnt_r - ONE_C;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired_o = (cnt_r == ZERO_C);

endmodule

// File: rtl/accel_seq_driver.sv
// accel_seq_driver: runs a sweep of (a, b) operand pairs through one root
// accelerator (y = floor sqrt(a + floor cbrt b)) and returns each result as an
// {a, b, y} record over a valid/ready port.
//   clk_i, rst_i              : clock, asynchronous active-high reset
//   start_i, a_start_i,
//   b_start_i, count_i        : sweep request, sampled only when idle
//   busy_o, done_o, err_o     : sweep status (done pulses, err is sticky)
//   acc_rst_o, acc_a_o,
//   acc_b_o                   : accelerator launch/reset and operands
//   acc_busy_i, acc_y_i       : accelerator status and result
//   res_valid_o, res_ready_i,
//   res_a_o, res_b_o, res_y_o : result record handshake
module accel_seq_driver
  import accel_seq_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] a_start_i,
  input  logic [DATA_W-1:0] b_start_i,
  input  logic [CNT_W-1:0]  count_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              acc_rst_o,
  output logic [DATA_W-1:0] acc_a_o,
  output logic [DATA_W-1:0] acc_b_o,
  input  logic              acc_busy_i,
  input  logic [DATA_W-1:0] acc_y_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [DATA_W-1:0] res_a_o,
  output logic [DATA_W-1:0] res_b_o,
  output logic [DATA_W-1:0] res_y_o
);

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] y;
  } rec_t;

  localparam logic [DATA_W-1:0] D_ZERO = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] D_ONE  = DATA_W'(1);
  localparam logic [CNT_W-1:0]  C_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  C_ONE  = CNT_W'(1);

  seq_state_e        state_r, state_s;
  logic [DATA_W-1:0] a_r, a_s, b_r, b_s;
  logic [CNT_W-1:0]  rem_r, rem_s;
  rec_t              rec_r, rec_s;
  logic              valid_r, valid_s;
  logic              err_r, err_s;
  logic              done_r, done_s;
  logic              busy_r, busy_s;
  logic              acc_rst_r, acc_rst_s;
  logic              to_load_s, to_dec_s, to_expired_s;

  accel_seq_timeout #(
    .LOAD_VAL (TIMEOUT)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (to_load_s),
    .dec_i     (to_dec_s),
    .expired_o (to_expired_s)
  );

  // Next-state and next-output logic for the sweep FSM.
  always_comb begin
    state_s   = state_r;
    a_s       = a_r;
    b_s       = b_r;
    rem_s     = rem_r;
    rec_s     = rec_r;
    valid_s   = valid_r;
    err_s     = err_r;
    done_s    = 1'b0;
    to_load_s = 1'b0;
    to_dec_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_i) begin
          if (count_i == C_ZERO) begin
            done_s = 1'b1;
          end else begin
            a_s     = a_start_i;
            b_s     = b_start_i;
            rem_s   = count_i;
            err_s   = 1'b0;
            state_s = LAUNCH;
          end
        end else begin
          state_s = IDLE;
        end
      end
      LAUNCH: begin
        state_s = GUARD;
      end
      GUARD: begin
        // busy from the accelerator may not have risen yet; only arm the watchdog
        to_load_s = 1'b1;
        state_s   = WAIT;
      end
      WAIT: begin
        if (!acc_busy_i) begin
          rec_s   = '{a: a_r, b: b_r, y: acc_y_i};
          valid_s = 1'b1;
          state_s = REPORT;
        end else if (to_expired_s) begin
          err_s   = 1'b1;
          done_s  = 1'b1;
          state_s = IDLE;
        end else begin
          to_dec_s = 1'b1;
        end
      end
      REPORT: begin
        if (res_ready_i) begin
          valid_s = 1'b0;
          rem_s   = rem_r - C_ONE;
          a_s     = a_r + D_ONE;
          b_s     = b_r + D_ONE;
          if (rem_r == C_ONE) begin
            done_s  = 1'b1;
            state_s = IDLE;
          end else begin
            state_s = LAUNCH;
          end
        end else begin
          state_s = REPORT;
        end
      end
      default: begin
        valid_s = 1'b0;
        state_s = IDLE;
      end
    endcase
    // Status outputs are registered from the state being entered so they line up with it.
    busy_s    = (state_s != IDLE);
    acc_rst_s = !((state_s == GUARD) || (state_s == WAIT));
  end

  // State, operand counters and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r   <= IDLE;
      a_r       <= D_ZERO;
      b_r       <= D_ZERO;
      rem_r     <= C_ZERO;
      rec_r     <= '{a: D_ZERO, b: D_ZERO, y: D_ZERO};
      valid_r   <= 1'b0;
      err_r     <= 1'b0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
      acc_rst_r <= 1'b1;
    end else begin
      state_r   <= state_s;
      a_r       <= a_s;
      b_r       <= b_s;
      rem_r     <= rem_s;
      rec_r     <= rec_s;
      valid_r   <= valid_s;
      err_r     <= err_s;
      done_r    <= done_s;
      busy_r    <= busy_s;
      acc_rst_r <= acc_rst_s;
    end
  end

  assign busy_o      = busy_r;
  assign done_o      = done_r;
  assign err_o       = err_r;
  assign acc_rst_o   = acc_rst_r;
  assign acc_a_o     = a_r;
  assign acc_b_o     = b_r;
  assign res_valid_o = valid_r;
  assign res_a_o     = rec_r.a;
  assign res_b_o     = rec_r.b;
  assign res_y_o     = rec_r.y;

endmodule

// File: tb/tb_accel_seq_driver.sv
// tb_accel_seq_driver: randomized sweeps against a behavioural reference.
// The expected record list of a sweep is computed up front from the start
// operands; a behavioural accelerator (1-cycle busy-rise, configurable latency,
// optional hang) answers launches; one compare process checks every handshake
// and the per-cycle output rules.
module tb_accel_seq_driver;

  localparam int DW = 8;
  localparam int CW = 9;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] a_start = '0, b_start = '0;
  logic [CW-1:0] count = '0;
  logic          busy_o, done_o, err_o, acc_rst_o;
  logic [DW-1:0] acc_a_o, acc_b_o, res_a_o, res_b_o, res_y_o;
  logic          acc_busy = 1'b0;
  logic [DW-1:0] acc_y = '0;
  logic          res_valid_o;
  logic          res_ready = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {int a; int b; int y;} rec_t;
  rec_t exp_q[$];
  int   got_y[$];
  int   launch_cnt = 0;
  int   last_cycles = 0;
  int   rdy_mode = 0;     // 0: always ready, 1: random, 2: 5-cycle stall per record
  int   lat_cfg = 3;      // 0: random latency per job
  bit   hang = 1'b0;

  accel_seq_driver #(.DATA_W(DW), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .a_start_i(a_start), .b_start_i(b_start), .count_i(count),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .acc_rst_o(acc_rst_o), .acc_a_o(acc_a_o), .acc_b_o(acc_b_o),
    .acc_busy_i(acc_busy), .acc_y_i(acc_y),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready),
    .res_a_o(res_a_o), .res_b_o(res_b_o), .res_y_o(res_y_o)
  );

  always #5 clk = ~clk;

  function automatic int ref_y(int a, int b);
    int c, s, r;
    c = 0;
    while ((c + 1) * (c + 1) * (c + 1) <= b) c++;
    s = a + c;
    r = 0;
    while ((r + 1) * (r + 1) <= s) r++;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural accelerator: busy rises one cycle after reset release.
  initial begin
    int phase, cnt;
    phase = 0;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (acc_rst_o) begin
        acc_busy = 1'b0;
        phase = 0;
      end else begin
        case (phase)
          0: phase = 1;
          1: begin
            acc_busy = 1'b1;
            acc_y = DW'($urandom);
            cnt = (lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 8));
            phase = 2;
          end
          2: if (!hang) begin
            if (cnt == 1) begin
              acc_busy = 1'b0;
              acc_y = DW'(ref_y(int'(acc_a_o), int'(acc_b_o)));
              phase = 3;
            end else begin
              cnt--;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Consumer ready generator.
  initial begin
    int st;
    st = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) res_ready = 1'b1;
      else if (rdy_mode == 1) res_ready = 1'($urandom_range(0, 1));
      else if (!res_valid_o) begin res_ready = 1'b0; st = 0; end
      else if (st < 5) begin res_ready = 1'b0; st++; end
      else res_ready = 1'b1;
    end
  end

  // Compare process: handshakes against the expected list, plus per-cycle rules.
  initial begin
    rec_t e;
    bit   prev_stall, prev_acc_rst;
    int   prev_rec, prev_ops;
    prev_stall = 1'b0;
    prev_acc_rst = 1'b1;
    prev_rec = 0;
    prev_ops = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        prev_acc_rst = 1'b1;
      end else begin
        if (res_valid_o && res_ready) begin
          got_y.push_back(int'(res_y_o));
          if (exp_q.size() == 0) chk("unexpected_record", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("rec_a", int'(res_a_o), e.a);
            chk("rec_b", int'(res_b_o), e.b);
            chk("rec_y", int'(res_y_o), e.y);
          end
        end
        if (prev_stall) chk("rec_stable", int'({res_valid_o, res_a_o, res_b_o, res_y_o}), prev_rec);
        if (res_valid_o) chk("acc_rst_in_report", int'(acc_rst_o), 1);
        if (!acc_rst_o && !prev_acc_rst) chk("operand_stable", int'({acc_a_o, acc_b_o}), prev_ops);
        if (prev_acc_rst && !acc_rst_o) launch_cnt++;
        prev_stall = res_valid_o && !res_ready;
        prev_rec = int'({1'b1, res_a_o, res_b_o, res_y_o});
        prev_acc_rst = acc_rst_o;
        prev_ops = int'({acc_a_o, acc_b_o});
      end
    end
  end

  task automatic run_sweep(input int a0, input int b0, input int cnt, input bit hng, input int poke_at);
    int  n, gaps;
    bit  seen;
    hang = hng;
    got_y.delete();
    if (!hng) begin
      for (int i = 0; i < cnt; i++) begin
        exp_q.push_back('{a: (a0 + i) % 256, b: (b0 + i) % 256,
                          y: ref_y((a0 + i) % 256, (b0 + i) % 256)});
      end
    end
    @(posedge clk);
    #1;
    a_start = DW'(a0);
    b_start = DW'(b0);
    count = CW'(cnt);
    start = 1'b1;
    launch_cnt = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_start = DW'($urandom);
    b_start = DW'($urandom);
    count = CW'($urandom_range(1, 5));
    n = 0;
    gaps = 0;
    seen = 1'b0;
    while (n < 3000 && !seen) begin
      @(negedge clk);
      n++;
      if (n == 1) chk("err_cleared_on_start", int'(err_o), 0);
      if (n == poke_at) start = 1'b1;
      if (n == poke_at + 1) start = 1'b0;
      if (done_o) seen = 1'b1;
      else if (!busy_o) gaps++;
    end
    start = 1'b0;
    last_cycles = n;
    if (!seen) chk("done_timeout", 0, 1);
    else begin
      chk("busy_at_done", int'(busy_o), 0);
      chk("busy_gaps", gaps, 0);
      chk("err_after_sweep", int'(err_o), int'(hng));
      chk("records_left", exp_q.size(), 0);
      if (!hng) chk("launches", launch_cnt, cnt);
      @(negedge clk);
      chk("done_single_pulse", int'(done_o), 0);
    end
    exp_q.delete();
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_acc_rst"}, int'(acc_rst_o), 1);
    chk({tag, "_busy"}, int'(busy_o), 0);
    chk({tag, "_done"}, int'(done_o), 0);
    chk({tag, "_err"}, int'(err_o), 0);
    chk({tag, "_valid"}, int'(res_valid_o), 0);
    chk({tag, "_acc_ops"}, int'({acc_a_o, acc_b_o}), 0);
    chk({tag, "_rec"}, int'({res_a_o, res_b_o, res_y_o}), 0);
  endtask

  initial begin
    int n;
    bit ok;
    repeat (3) @(negedge clk);
    chk_reset_values("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic sweep, fixed latency 3: 3 jobs of L+4 cycles, done one cycle later.
    rdy_mode = 0;
    lat_cfg = 3;
    run_sweep(0, 0, 3, 1'b0, 0);
    chk("basic_cycles", last_cycles, 22);
    chk("basic_nrec", got_y.size(), 3);
    if (got_y.size() == 3) chk("basic_y_seq", got_y[0] * 100 + got_y[1] * 10 + got_y[2], 11);

    // Mixed operands, hand-computed results.
    lat_cfg = 0;
    run_sweep(5, 8, 1, 1'b0, 0);
    chk("mixed_5_8_y", (got_y.size() == 1) ? got_y[0] : -1, 2);
    run_sweep(14, 27, 1, 1'b0, 0);
    chk("mixed_14_27_y", (got_y.size() == 1) ? got_y[0] : -1, 4);

    // Wrap-around of both operands.
    run_sweep(255, 254, 3, 1'b0, 0);

    // Backpressure: 5 stall cycles per record.
    rdy_mode = 2;
    run_sweep(40, 100, 2, 1'b0, 0);
    chk("bp_nrec", got_y.size(), 2);
    rdy_mode = 0;

    // Timeout: accelerator never drops busy.
    run_sweep(3, 3, 2, 1'b1, 0);
    chk("timeout_cycles", last_cycles, 3 + TO);
    run_sweep(9, 64, 1, 1'b0, 0);
    chk("after_timeout_y", (got_y.size() == 1) ? got_y[0] : -1, 3);

    // Zero-length sweep.
    @(posedge clk);
    #1;
    count = '0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("zero_done", int'(done_o), 1);
    chk("zero_busy", int'(busy_o), 0);
    chk("zero_acc_rst", int'(acc_rst_o), 1);
    @(negedge clk);
    chk("zero_done_clear", int'(done_o), 0);

    // Start pulsed mid-sweep must be ignored.
    run_sweep(10, 20, 3, 1'b0, 5);

    // Randomized sweeps.
    for (int k = 0; k < 25; k++) begin
      rdy_mode = int'($urandom_range(0, 2));
      run_sweep(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                int'($urandom_range(1, 6)), 1'b0, (k % 4 == 0) ? 4 : 0);
    end
    rdy_mode = 0;

    // Asynchronous reset while the accelerator is busy in WAIT.
    lat_cfg = 6;
    hang = 1'b0;
    @(posedge clk);
    #1;
    a_start = 8'd7;
    b_start = 8'd9;
    count = 9'd4;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    ok = 1'b0;
    while (n < 200 && !ok) begin
      @(negedge clk);
      n++;
      if (!acc_rst_o && acc_busy) ok = 1'b1;
    end
    chk("reach_wait", int'(ok), 1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_values("async_reset");
    @(posedge clk);
    #1;
    exp_q.delete();
    rst = 1'b0;

    lat_cfg = 0;
    run_sweep(100, 200, 2, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
